// File: rtl/mem_stage.sv
// Memory-access stage between EX and WB: registers EX results, issues one load/store at a time.
// Latency: 1 cycle for non-memory ops and misaligned accesses, 3 cycles for a zero-wait memory access.
// Backpressure: in_ready_o is low while an access is in REQ or RESP; the request is held until dmem_req_ready_i.
module mem_stage #(
  parameter int XLEN     = 64,
  parameter int INST_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [XLEN-1:0]     pc_i,
  input  logic [INST_LEN-1:0] instr_i,
  input  logic [XLEN-1:0]     alures_i,
  input  logic [XLEN-1:0]     stdata_i,
  input  logic [XLEN-1:0]     csrdata_i,
  output logic                dmem_req_valid_o,
  input  logic                dmem_req_ready_i,
  output logic [XLEN-1:0]     dmem_addr_o,
  output logic                dmem_wen_o,
  output logic [XLEN-1:0]     dmem_wdata_o,
  output logic [7:0]          dmem_wmask_o,
  input  logic                dmem_rvalid_i,
  input  logic [XLEN-1:0]     dmem_rdata_i,
  output logic                wb_valid_o,
  output logic [XLEN-1:0]     wb_pc_o,
  output logic [INST_LEN-1:0] wb_instr_o,
  output logic [XLEN-1:0]     wb_alures_o,
  output logic [XLEN-1:0]     wb_csrdata_o,
  output logic [XLEN-1:0]     wb_lsres_o,
  output logic                misalign_o
);

  localparam logic [4:0] OPC_LOAD  = 5'b00000;
  localparam logic [4:0] OPC_STORE = 5'b01000;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t              state_q, state_d;
  logic [XLEN-1:0]     wb_pc_q, wb_pc_d;
  logic [INST_LEN-1:0] wb_instr_q, wb_instr_d;
  logic [XLEN-1:0]     wb_alures_q, wb_alures_d;
  logic [XLEN-1:0]     wb_csrdata_q, wb_csrdata_d;
  logic [XLEN-1:0]     wb_lsres_q, wb_lsres_d;
  logic [XLEN-1:0]     stdata_q, stdata_d;
  logic                wb_valid_q, wb_valid_d;
  logic                misalign_q, misalign_d;

  // Incoming instruction decode
  logic       in_load, in_store, in_mem, in_aligned;
  logic [2:0] in_off;

  // Decode of the latched access (wb_instr_q / wb_alures_q hold it during REQ/RESP)
  logic            acc_load, acc_store, acc_sext;
  logic [1:0]      acc_size;
  logic [2:0]      acc_off;
  logic [XLEN-1:0] ld_shift, ld_fmt;
  logic [XLEN-1:0] st_wdata;
  logic [7:0]      st_base_mask, st_wmask;
  logic            req_active;

  // Decode the EX instruction and check natural alignment of its address
  always_comb begin
    in_load    = (instr_i[6:2] == OPC_LOAD);
    in_store   = (instr_i[6:2] == OPC_STORE);
    in_mem     = in_load | in_store;
    in_off     = alures_i[2:0];
    in_aligned = 1'b1;
    case (instr_i[13:12])
      2'd0:    in_aligned = 1'b1;
      2'd1:    in_aligned = (in_off[0] == 1'b0);
      2'd2:    in_aligned = (in_off[1:0] == 2'b00);
      default: in_aligned = (in_off == 3'b000);
    endcase
  end

  // Lane placement for stores and extraction/extension for loads
  always_comb begin
    acc_load  = (wb_instr_q[6:2] == OPC_LOAD);
    acc_store = (wb_instr_q[6:2] == OPC_STORE);
    acc_size  = wb_instr_q[13:12];
    acc_sext  = ~wb_instr_q[14];
    acc_off   = wb_alures_q[2:0];

    st_wdata = stdata_q << {acc_off, 3'b000};
    case (acc_size)
      2'd0:    st_base_mask = 8'h01;
      2'd1:    st_base_mask = 8'h03;
      2'd2:    st_base_mask = 8'h0F;
      default: st_base_mask = 8'hFF;
    endcase
    st_wmask = st_base_mask << acc_off;

    ld_shift = dmem_rdata_i >> {acc_off, 3'b000};
    case (acc_size)
      2'd0:    ld_fmt = {{(XLEN-8){acc_sext & ld_shift[7]}}, ld_shift[7:0]};
      2'd1:    ld_fmt = {{(XLEN-16){acc_sext & ld_shift[15]}}, ld_shift[15:0]};
      2'd2:    ld_fmt = {{(XLEN-32){acc_sext & ld_shift[31]}}, ld_shift[31:0]};
      default: ld_fmt = ld_shift;
    endcase
  end

  // Next-state: accept in IDLE, hold request in REQ, take the response only in RESP
  always_comb begin
    state_d      = state_q;
    wb_pc_d      = wb_pc_q;
    wb_instr_d   = wb_instr_q;
    wb_alures_d  = wb_alures_q;
    wb_csrdata_d = wb_csrdata_q;
    wb_lsres_d   = wb_lsres_q;
    stdata_d     = stdata_q;
    wb_valid_d   = 1'b0;
    misalign_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          wb_pc_d      = pc_i;
          wb_instr_d   = instr_i;
          wb_alures_d  = alures_i;
          wb_csrdata_d = csrdata_i;
          stdata_d     = stdata_i;
          wb_lsres_d   = '0;
          if (in_mem && in_aligned) begin
            state_d = REQ;
          end else begin
            // Non-memory ops and misaligned accesses retire without touching memory
            wb_valid_d = 1'b1;
            misalign_d = in_mem;
          end
        end
      end
      REQ: begin
        if (dmem_req_ready_i) state_d = RESP;
      end
      RESP: begin
        if (dmem_rvalid_i) begin
          wb_lsres_d = acc_load ? ld_fmt : '0;
          wb_valid_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and pipeline registers; synchronous reset drops any access in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wb_pc_q      <= '0;
      wb_instr_q   <= '0;
      wb_alures_q  <= '0;
      wb_csrdata_q <= '0;
      wb_lsres_q   <= '0;
      stdata_q     <= '0;
      wb_valid_q   <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wb_pc_q      <= wb_pc_d;
      wb_instr_q   <= wb_instr_d;
      wb_alures_q  <= wb_alures_d;
      wb_csrdata_q <= wb_csrdata_d;
      wb_lsres_q   <= wb_lsres_d;
      stdata_q     <= stdata_d;
      wb_valid_q   <= wb_valid_d;
      misalign_q   <= misalign_d;
    end
  end

  // Request fields are decoded from held registers, so they stay stable while waiting
  always_comb begin
    req_active       = (state_q == REQ);
    in_ready_o       = (state_q == IDLE);
    dmem_req_valid_o = req_active;
    dmem_addr_o      = req_active ? {wb_alures_q[XLEN-1:3], 3'b000} : '0;
    dmem_wen_o       = req_active & acc_store;
    dmem_wdata_o     = (req_active && acc_store) ? st_wdata : '0;
    dmem_wmask_o     = (req_active && acc_store) ? st_wmask : 8'h00;
  end

  assign wb_valid_o   = wb_valid_q;
  assign wb_pc_o      = wb_pc_q;
  assign wb_instr_o   = wb_instr_q;
  assign wb_alures_o  = wb_alures_q;
  assign wb_csrdata_o = wb_csrdata_q;
  assign wb_lsres_o   = wb_lsres_q;
  assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed test-plan cases plus randomized ops against a behavioural model.
// Inputs are driven and outputs sampled at the falling edge; the DUT is clocked on the rising edge.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [63:0] pc_i;
  logic [31:0] instr_i;
  logic [63:0] alures_i, stdata_i, csrdata_i;
  logic        dmem_req_valid_o, dmem_req_ready_i;
  logic [63:0] dmem_addr_o;
  logic        dmem_wen_o;
  logic [63:0] dmem_wdata_o;
  logic [7:0]  dmem_wmask_o;
  logic        dmem_rvalid_i;
  logic [63:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic [63:0] wb_pc_o;
  logic [31:0] wb_instr_o;
  logic [63:0] wb_alures_o, wb_csrdata_o, wb_lsres_o;
  logic        misalign_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(64), .INST_LEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .pc_i(pc_i), .instr_i(instr_i), .alures_i(alures_i),
    .stdata_i(stdata_i), .csrdata_i(csrdata_i),
    .dmem_req_valid_o(dmem_req_valid_o), .dmem_req_ready_i(dmem_req_ready_i),
    .dmem_addr_o(dmem_addr_o), .dmem_wen_o(dmem_wen_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_wmask_o(dmem_wmask_o),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_pc_o(wb_pc_o), .wb_instr_o(wb_instr_o),
    .wb_alures_o(wb_alures_o), .wb_csrdata_o(wb_csrdata_o),
    .wb_lsres_o(wb_lsres_o), .misalign_o(misalign_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic logic [31:0] mk_instr(input logic [4:0] opc, input logic [2:0] f3);
    return {17'h0, f3, 5'd1, opc, 2'b11};
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_aligned(input logic [63:0] addr, input logic [2:0] f3);
    return (addr % nbytes(f3)) == 0;
  endfunction

  function automatic logic [7:0] model_wmask(input logic [63:0] addr, input logic [2:0] f3);
    int m;
    m = ((1 << nbytes(f3)) - 1) << addr[2:0];
    return 8'(m & 255);
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] rd, input logic [63:0] addr,
                                             input logic [2:0] f3);
    logic [63:0] v;
    int nb;
    nb = 8 * nbytes(f3);
    v  = rd >> (8 * addr[2:0]);
    if (nb < 64) begin
      v = v & ((64'd1 << nb) - 64'd1);
      if (!f3[2] && v[nb-1]) v = v - (64'd1 << nb);
    end
    return v;
  endfunction

  // Drive one instruction through the stage with the given memory timing and check every cycle.
  // Enters and leaves at a falling edge with the DUT idle.
  task automatic run_op(input string nm, input logic [63:0] pc, input logic [4:0] opc,
                        input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] st,
                        input logic [63:0] csr, input logic [63:0] rd,
                        input int req_st, input int resp_st, input bit collide);
    bit is_ld, is_st, mem, al;
    logic [31:0] ins;
    ins   = mk_instr(opc, f3);
    is_ld = (opc == 5'b00000);
    is_st = (opc == 5'b01000);
    mem   = is_ld || is_st;
    al    = is_aligned(addr, f3);

    chk({nm, ".in_ready_idle"}, 64'(in_ready_o), 64'd1);
    in_valid_i = 1'b1; pc_i = pc; instr_i = ins; alures_i = addr;
    stdata_i = st; csrdata_i = csr;
    @(negedge clk);
    in_valid_i = 1'b0; pc_i = '0; instr_i = '0; alures_i = '0; stdata_i = '0; csrdata_i = '0;

    if (mem && al) begin
      for (int i = 0; i <= req_st; i++) begin
        chk({nm, ".req_valid"}, 64'(dmem_req_valid_o), 64'd1);
        chk({nm, ".req_addr"}, dmem_addr_o, addr & ~64'h7);
        chk({nm, ".req_wen"}, 64'(dmem_wen_o), 64'(is_st));
        if (is_st) begin
          chk({nm, ".req_wdata"}, dmem_wdata_o, st << (8 * addr[2:0]));
          chk({nm, ".req_wmask"}, 64'(dmem_wmask_o), 64'(model_wmask(addr, f3)));
        end
        chk({nm, ".req_in_ready"}, 64'(in_ready_o), 64'd0);
        chk({nm, ".req_wb_valid"}, 64'(wb_valid_o), 64'd0);
        dmem_req_ready_i = (i == req_st);
        dmem_rvalid_i    = collide && (i == req_st);
        dmem_rdata_i     = ~rd;
        @(negedge clk);
      end
      dmem_req_ready_i = 1'b0;
      dmem_rvalid_i    = 1'b0;
      for (int i = 0; i <= resp_st; i++) begin
        chk({nm, ".resp_req_valid"}, 64'(dmem_req_valid_o), 64'd0);
        chk({nm, ".resp_in_ready"}, 64'(in_ready_o), 64'd0);
        chk({nm, ".resp_wb_valid"}, 64'(wb_valid_o), 64'd0);
        dmem_rvalid_i = (i == resp_st);
        dmem_rdata_i  = (i == resp_st) ? rd : {$urandom, $urandom};
        @(negedge clk);
      end
      dmem_rvalid_i = 1'b0;
      dmem_rdata_i  = '0;
    end else begin
      chk({nm, ".no_req"}, 64'(dmem_req_valid_o), 64'd0);
    end

    chk({nm, ".wb_valid"}, 64'(wb_valid_o), 64'd1);
    chk({nm, ".misalign"}, 64'(misalign_o), 64'(mem && !al));
    chk({nm, ".lsres"}, wb_lsres_o, (is_ld && al) ? model_load(rd, addr, f3) : 64'd0);
    chk({nm, ".alures"}, wb_alures_o, addr);
    chk({nm, ".pc"}, wb_pc_o, pc);
    chk({nm, ".instr"}, 64'(wb_instr_o), 64'(ins));
    chk({nm, ".csr"}, wb_csrdata_o, csr);
    chk({nm, ".ready_after"}, 64'(in_ready_o), 64'd1);
    @(negedge clk);
    chk({nm, ".wb_pulse"}, 64'(wb_valid_o), 64'd0);
    chk({nm, ".misalign_pulse"}, 64'(misalign_o), 64'd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".in_ready"}, 64'(in_ready_o), 64'd1);
    chk({nm, ".req_valid"}, 64'(dmem_req_valid_o), 64'd0);
    chk({nm, ".addr"}, dmem_addr_o, 64'd0);
    chk({nm, ".wen"}, 64'(dmem_wen_o), 64'd0);
    chk({nm, ".wdata"}, dmem_wdata_o, 64'd0);
    chk({nm, ".wmask"}, 64'(dmem_wmask_o), 64'd0);
    chk({nm, ".wb_valid"}, 64'(wb_valid_o), 64'd0);
    chk({nm, ".wb_pc"}, wb_pc_o, 64'd0);
    chk({nm, ".wb_instr"}, 64'(wb_instr_o), 64'd0);
    chk({nm, ".wb_alures"}, wb_alures_o, 64'd0);
    chk({nm, ".wb_csr"}, wb_csrdata_o, 64'd0);
    chk({nm, ".wb_lsres"}, wb_lsres_o, 64'd0);
    chk({nm, ".misalign"}, 64'(misalign_o), 64'd0);
  endtask

  initial begin
    logic [63:0] a;
    rst = 1'b1; in_valid_i = 1'b0; pc_i = '0; instr_i = '0; alures_i = '0;
    stdata_i = '0; csrdata_i = '0; dmem_req_ready_i = 1'b0; dmem_rvalid_i = 1'b0;
    dmem_rdata_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_all_zero("reset");

    // ALU op: one-cycle latency, lsres zero
    run_op("add", 64'h100, 5'b01100, 3'b000, 64'h1234, 64'h0, 64'h55, 64'h0, 0, 0, 0);

    // Three back-to-back ALU ops produce three consecutive wb pulses
    in_valid_i = 1'b1; instr_i = mk_instr(5'b01100, 3'b000);
    for (int i = 0; i < 3; i++) begin
      a = 64'h10 + 64'(i);
      alures_i = a;
      @(negedge clk);
      chk("b2b.wb_valid", 64'(wb_valid_o), 64'd1);
      chk("b2b.alures", wb_alures_o, a);
      chk("b2b.in_ready", 64'(in_ready_o), 64'd1);
    end
    in_valid_i = 1'b0;
    @(negedge clk);
    chk("b2b.wb_end", 64'(wb_valid_o), 64'd0);

    // LB / LBU at 0x1003, zero-wait memory
    run_op("lb", 64'h200, 5'b00000, 3'b000, 64'h1003, 64'h0, 64'h0, 64'h00000000_80000000, 0, 0, 0);
    chk("lb.const", wb_lsres_o, 64'hFFFFFFFF_FFFFFF80);
    run_op("lbu", 64'h204, 5'b00000, 3'b100, 64'h1003, 64'h0, 64'h0, 64'h00000000_80000000, 0, 0, 0);
    chk("lbu.const", wb_lsres_o, 64'h80);

    // SH at 0x2006
    run_op("sh", 64'h300, 5'b01000, 3'b001, 64'h2006, 64'hABCD, 64'h0, 64'h0, 0, 0, 0);

    // LW with request and response stalls
    run_op("lw", 64'h400, 5'b00000, 3'b010, 64'h3004, 64'h0, 64'h0, 64'h87654321_00000000, 4, 2, 0);
    chk("lw.const", wb_lsres_o, 64'hFFFFFFFF_87654321);

    // Misaligned LD
    run_op("ld_mis", 64'h500, 5'b00000, 3'b011, 64'h4004, 64'h0, 64'h0, 64'h0, 0, 0, 0);

    // Response presented in the REQ handshake cycle must be ignored
    run_op("collide", 64'h600, 5'b00000, 3'b011, 64'h5000, 64'h0, 64'h0, 64'h0123456789ABCDEF, 1, 1, 1);

    // Reset while in RESP, then a late response in IDLE
    in_valid_i = 1'b1; pc_i = 64'h700; instr_i = mk_instr(5'b00000, 3'b011);
    alures_i = 64'h6000; csrdata_i = 64'h77;
    @(negedge clk);
    in_valid_i = 1'b0; dmem_req_ready_i = 1'b1;
    @(negedge clk);
    dmem_req_ready_i = 1'b0;
    chk("rst_mid.in_resp", 64'(in_ready_o), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("rst_mid");
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'hDEADBEEF_CAFEF00D;
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    chk("late_rvalid.wb_valid", 64'(wb_valid_o), 64'd0);
    chk("late_rvalid.lsres", wb_lsres_o, 64'd0);
    chk("late_rvalid.in_ready", 64'(in_ready_o), 64'd1);

    // Randomized mix of ALU, load and store ops with random stalls
    for (int n = 0; n < 80; n++) begin
      logic [4:0]  opc;
      logic [2:0]  f3;
      int          kind;
      kind = int'($urandom_range(0, 2));
      opc  = (kind == 0) ? 5'b01100 : (kind == 1) ? 5'b00000 : 5'b01000;
      f3   = 3'($urandom_range(0, 7));
      run_op("rand", {$urandom, $urandom}, opc, f3, {$urandom, $urandom},
             {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between EX and WB. Registers EX results and performs load/store through a single-outstanding request/response data-memory port.
- Produces the aligned, sign/zero-extended load result (lsres) and the pass-through alures/csrdata/pc/instr consumed by the write-back stage.
- Stalls EX via in_ready_o while a memory access is in flight.

Parameters:
- XLEN, 64, datapath width; this block supports only 64.
- INST_LEN, 32, instruction width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid_i  in  1  EX presents an instruction
- in_ready_o  out  1  stage accepts; transfer occurs when in_valid_i and in_ready_o are both high
- pc_i  in  XLEN  instruction pc
- instr_i  in  INST_LEN  instruction word
- alures_i  in  XLEN  ALU result; this is the effective address for load/store
- stdata_i  in  XLEN  rs2 store data
- csrdata_i  in  XLEN  CSR read data
- dmem_req_valid_o  out  1  memory request valid
- dmem_req_ready_i  in  1  memory accepts request
- dmem_addr_o  out  XLEN  8-byte-aligned address (alures with bits [2:0] forced to 0)
- dmem_wen_o  out  1  1 = store
- dmem_wdata_o  out  XLEN  store data shifted into byte lanes
- dmem_wmask_o  out  8  byte-enable mask
- dmem_rvalid_i  in  1  response valid; stores also receive one response
- dmem_rdata_i  in  XLEN  raw 64-bit read data
- wb_valid_o  out  1  one-cycle pulse: WB outputs valid
- wb_pc_o, wb_instr_o, wb_alures_o, wb_csrdata_o  out  XLEN/INST_LEN/XLEN/XLEN  registered pass-through values
- wb_lsres_o  out  XLEN  formatted load result; 0 for non-loads
- misalign_o  out  1  pulse together with wb_valid_o when the access was misaligned

Behaviour:
- Reset: state IDLE, in_ready_o = 1, all dmem_* outputs 0, all wb_* outputs 0, misalign_o = 0. A reset taken mid-access abandons the access. A late dmem_rvalid_i arriving in IDLE is ignored.
- Decode:
  - load: instr[6:2] = 00000
  - store: instr[6:2] = 01000
  - size: instr[13:12] (0 = byte, 1 = half, 2 = word, 3 = double)
  - unsigned load: instr[14]
- FSM: IDLE, REQ, RESP.
- IDLE (in_ready_o = 1), on accept:
  - Non-memory instruction: latch into wb_* registers. wb_valid_o = 1 next cycle, wb_lsres_o = 0, stay in IDLE. Back-to-back accepts are allowed: throughput 1 per cycle, latency 1.
  - Memory instruction, aligned (byte any address; half addr[0] = 0; word addr[1:0] = 0; double addr[2:0] = 0): latch pc/instr/alures/stdata/csrdata, go to REQ.
  - Memory instruction, misaligned: no request issued. Next cycle wb_valid_o = 1, misalign_o = 1, wb_lsres_o = 0. Stay in IDLE.
- REQ (in_ready_o = 0):
  - dmem_req_valid_o = 1, with addr/wen/wdata/wmask held stable until dmem_req_ready_i.
  - On dmem_req_ready_i, go to RESP the next cycle; dmem_req_valid_o drops.
  - If dmem_req_ready_i and dmem_rvalid_i are high in the same cycle, the response is not accepted (responses are accepted only in RESP).
- RESP (in_ready_o = 0): on dmem_rvalid_i, capture the formatted result. Next cycle wb_valid_o = 1 and state returns to IDLE, where a new accept is allowed that same cycle.
- Store lanes:
  - wdata = stdata << (8*addr[2:0]).
  - wmask = byte 8'h01, half 8'h03, word 8'h0F, double 8'hFF, each shifted left by addr[2:0].
- Load format:
  - Shift rdata right by 8*addr[2:0].
  - Take the low 8/16/32/64 bits.
  - Sign-extend, or zero-extend when instr[14] = 1.
- Store wb_lsres_o = 0.
- Minimum load latency (accept to wb_valid_o): 3 cycles with zero-wait memory. Each stall cycle in REQ or RESP adds 1.

Test Plan:
- ADD (opcode 01100), alures 0x1234: accepted at cycle 0, so wb_valid_o = 1 at cycle 1 with wb_alures_o = 0x1234, wb_lsres_o = 0. Three back-to-back ALU ops give three consecutive wb_valid_o pulses.
- LB addr 0x1003, zero-wait memory, rdata 0x00000000_80000000: dmem_addr_o = 0x1000. Result is 0xFFFFFFFF_FFFFFF80; wb_valid_o fires 3 cycles after accept. LBU with the same inputs gives 0x80.
- SH addr 0x2006, stdata 0xABCD: wmask = 8'hC0, wdata = 0xABCD0000_00000000, wen = 1. wb_valid_o fires after rvalid, with lsres = 0.
- LW addr 0x3004, dmem_req_ready_i held low 4 cycles, then rvalid delayed 2 cycles, rdata 0x87654321_00000000: req signals stay stable throughout, in_ready_o stays 0, and the result is 0xFFFFFFFF_87654321.
- LD addr 0x4004 (misaligned): no dmem_req_valid_o. wb_valid_o = 1 and misalign_o = 1 the next cycle, lsres = 0.
- LD in RESP, rst asserted for 1 cycle, then rvalid arrives: all outputs 0, state IDLE, response ignored, no wb_valid_o.
